// File: rtl/alu_pkg.sv
// Shared definitions for the ALU shift controller: FSM state encoding,
// shift direction and shift_unit function codes.
package alu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int AMT_W_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic SHIFT_DIR_RIGHT = 1'b0;
    localparam logic SHIFT_DIR_LEFT  = 1'b1;

    // shift_unit function codes: MSB selects the operand port, LSB the direction
    localparam logic [1:0] FUNC_A_RIGHT = 2'b00;
    localparam logic [1:0] FUNC_A_LEFT  = 2'b01;
    localparam logic [1:0] FUNC_B_RIGHT = 2'b10;
    localparam logic [1:0] FUNC_B_LEFT  = 2'b11;

    function automatic logic [1:0] shift_func(input logic id, input logic dir);
        return {id, dir};
    endfunction

endpackage

// File: rtl/alu_shift_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, last-winner pointer updated
// only when the grant is actually taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last;

    // Grant the lone requester, or on a tie the one that did not win last.
    // NOTE: every always_comb output gets a default so no latch is inferred.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner; starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last <= 1'b1;
        else if (accept && (grant != 2'b00))
            last <= grant[1];
    end

endmodule

// File: rtl/alu_shift_ctrl.sv
// Shares one single-bit shift_unit between two requesters and sequences
// multi-bit shifts as repeated ISSUE/WAIT steps.
// Optional feature: define ALU_SHIFT_CTRL_OVF_EN to enable the left-shift
// sign-overflow flag on rsp_ovf; otherwise rsp_ovf is tied low.
module alu_shift_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int AMT_W    = AMT_W_DEF,
    parameter int SU_OUT_W = DATA_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [DATA_W-1:0]   req0_data,
    input  logic                req0_dir,
    input  logic [AMT_W-1:0]    req0_amt,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [DATA_W-1:0]   req1_data,
    input  logic                req1_dir,
    input  logic [AMT_W-1:0]    req1_amt,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_id,
    output logic                rsp_ovf,
    output logic                su_err,
    output logic                busy,
    output logic [DATA_W-1:0]   su_a,
    output logic [DATA_W-1:0]   su_b,
    output logic                su_enable,
    output logic [1:0]          su_func,
    input  logic [SU_OUT_W-1:0] su_out,
    input  logic                su_flag
);

    state_t            state;
    logic [DATA_W-1:0] cur;
    logic [AMT_W-1:0]  rem;
    logic              dir_q;
    logic              id_q;
    logic              err_q;
    logic              ovf;
    logic [1:0]        grant;
    logic              idle;
    logic              accept;
    logic              unused_su_msb;

    // The unit's extra output bit carries nothing this controller needs.
    assign unused_su_msb = ^su_out[SU_OUT_W-1:DATA_W];

    // Ready is held low while reset is asserted so every output reads 0.
    assign idle       = (state == ST_IDLE) && rst;
    assign req0_ready = idle && grant[0];
    assign req1_ready = idle && grant[1];
    assign accept     = idle && (grant != 2'b00);
    assign busy       = (state != ST_IDLE);
    assign su_err     = err_q;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    // Main sequencer: accept, step the shift unit rem times, then respond.
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together at the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cur   <= '0;
            rem   <= '0;
            dir_q <= SHIFT_DIR_RIGHT;
            id_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur   <= grant[1] ? req1_data : req0_data;
                        dir_q <= grant[1] ? req1_dir  : req0_dir;
                        rem   <= grant[1] ? req1_amt  : req0_amt;
                        id_q  <= grant[1];
                        state <= ((grant[1] ? req1_amt : req0_amt) == '0) ? ST_RESP : ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    cur <= su_out[DATA_W-1:0];
                    if (!su_flag)
                        err_q <= 1'b1;
                    rem   <= rem - AMT_W'(1);
                    state <= (rem == AMT_W'(1)) ? ST_RESP : ST_ISSUE;
                end
                ST_RESP: begin
                    if (rsp_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_SHIFT_CTRL_OVF_EN
    logic ovf_q;

    // Sticky per transaction: any left step that changes the sign bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ovf_q <= 1'b0;
        else if (accept)
            ovf_q <= 1'b0;
        else if ((state == ST_WAIT) && (dir_q == SHIFT_DIR_LEFT) &&
                 (su_out[DATA_W-1] != cur[DATA_W-1]))
            ovf_q <= 1'b1;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // State decode for the shift-unit drive and the response channel.
    always_comb begin
        su_enable = 1'b0;
        su_func   = 2'b00;
        su_a      = '0;
        su_b      = '0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_id    = 1'b0;
        rsp_ovf   = 1'b0;
        case (state)
            ST_ISSUE: begin
                su_enable = 1'b1;
                su_func   = shift_func(id_q, dir_q);
                if (id_q) su_b = cur;
                else      su_a = cur;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = cur;
                rsp_id    = id_q;
                rsp_ovf   = ovf;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_shift_ctrl.sv
// Directed bench for alu_shift_ctrl with a behavioural single-step shift unit.
module tb_alu_shift_ctrl;

`ifdef ALU_SHIFT_CTRL_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_data = 0, req1_data = 0;
    logic        req0_dir = 0, req1_dir = 0;
    logic [3:0]  req0_amt = 0, req1_amt = 0;
    logic        rsp_valid, rsp_id, rsp_ovf, su_err, busy, su_enable, su_flag;
    logic        rsp_ready = 0;
    logic [15:0] rsp_data, su_a, su_b;
    logic [1:0]  su_func;
    logic [16:0] su_out;
    logic        flag_kill = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_shift_ctrl dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_dir(req0_dir), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_dir(req1_dir), .req1_amt(req1_amt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_ovf(rsp_ovf), .su_err(su_err), .busy(busy),
        .su_a(su_a), .su_b(su_b), .su_enable(su_enable), .su_func(su_func),
        .su_out(su_out), .su_flag(su_flag)
    );

    // Behavioural shift_unit: registered one-bit step, result valid next cycle.
    logic [15:0] su_opnd;
    assign su_opnd = su_func[1] ? su_b : su_a;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            su_out  <= '0;
            su_flag <= 1'b0;
        end else begin
            su_flag <= su_enable & ~flag_kill;
            if (su_enable)
                su_out <= su_func[0] ? {su_opnd, 1'b0}
                                     : 17'($signed({su_opnd[15], su_opnd}) >>> 1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Issue one command, wait for its response, optionally stall the consumer.
    task automatic do_op(input logic id, input logic [15:0] data, input logic dir,
                         input logic [3:0] amt, input int hold,
                         output logic [15:0] r_data, output logic r_id, output logic r_ovf,
                         output int lat, output int pulses,
                         output logic bus_ok, output logic stable_ok);
        logic got;
        @(negedge clk);
        if (id) begin
            req1_valid = 1; req1_data = data; req1_dir = dir; req1_amt = amt;
        end else begin
            req0_valid = 1; req0_data = data; req0_dir = dir; req0_amt = amt;
        end
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            #1;
            if (id ? req1_ready : req0_ready) got = 1;
            else @(negedge clk);
        end
        check("accept within bound", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 0;
        req1_valid = 0;
        lat = 0; pulses = 0; bus_ok = 1; got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (su_enable) begin
                pulses++;
                if (su_func !== {id, dir}) bus_ok = 0;
                if (id ? (su_a !== 16'h0) : (su_b !== 16'h0)) bus_ok = 0;
            end else if (su_a !== 16'h0 || su_b !== 16'h0) begin
                bus_ok = 0;
            end
            if (rsp_valid) got = 1;
        end
        check("response within bound", {31'd0, got}, 32'd1);
        r_data = rsp_data; r_id = rsp_id; r_ovf = rsp_ovf;
        stable_ok = 1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1 || busy !== 1 || rsp_data !== r_data ||
                rsp_id !== r_id || rsp_ovf !== r_ovf) stable_ok = 0;
        end
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
    endtask

    typedef struct {
        logic        id;
        logic [15:0] data;
        logic        dir;
        logic [3:0]  amt;
        logic [15:0] exp_data;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [15:0] r_data;
        logic        r_id, r_ovf, bus_ok, stable_ok, got;
        int          lat, pulses;
        int          order[$];

        vecs[0] = '{1'b0, 16'h0003, 1'b1, 4'd3,  16'h0018, 1'b0,   7};
        vecs[1] = '{1'b1, 16'h8000, 1'b0, 4'd4,  16'hF800, 1'b0,   9};
        vecs[2] = '{1'b0, 16'h4000, 1'b1, 4'd1,  16'h8000, OVF_ON, 3};
        vecs[3] = '{1'b0, 16'h1234, 1'b1, 4'd0,  16'h1234, 1'b0,   1};
        vecs[4] = '{1'b1, 16'h6000, 1'b1, 4'd2,  16'h8000, OVF_ON, 5};
        vecs[5] = '{1'b0, 16'h8000, 1'b0, 4'd15, 16'hFFFF, 1'b0,   31};
        vecs[6] = '{1'b1, 16'h7FFF, 1'b0, 4'd15, 16'h0000, 1'b0,   31};
        vecs[7] = '{1'b1, 16'h00F0, 1'b1, 4'd4,  16'h0F00, 1'b0,   9};
        vecs[8] = '{1'b0, 16'h0100, 1'b0, 4'd8,  16'h0001, 1'b0,   17};
        vecs[9] = '{1'b0, 16'h0001, 1'b1, 4'd15, 16'h8000, OVF_ON, 31};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset outputs", {rsp_valid, rsp_data, rsp_id, rsp_ovf, su_err, busy,
                                su_enable, su_func, req0_ready, req1_ready}, 32'd0);
        check("reset su_a/su_b", {su_a, su_b}, 32'd0);
        rst = 1'b1;

        // Table-driven single commands
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].id, vecs[i].data, vecs[i].dir, vecs[i].amt, 0,
                  r_data, r_id, r_ovf, lat, pulses, bus_ok, stable_ok);
            check($sformatf("v%0d rsp_data", i), {16'd0, r_data}, {16'd0, vecs[i].exp_data});
            check($sformatf("v%0d rsp_id", i), {31'd0, r_id}, {31'd0, vecs[i].id});
            check($sformatf("v%0d rsp_ovf", i), {31'd0, r_ovf}, {31'd0, vecs[i].exp_ovf});
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d su_enable pulses", i), pulses, {28'd0, vecs[i].amt});
            check($sformatf("v%0d su bus", i), {31'd0, bus_ok}, 32'd1);
        end
        @(negedge clk);
        check("idle after response", {30'd0, busy, rsp_valid}, 32'd0);
        check("no error with good flag", {31'd0, su_err}, 32'd0);

        // Stalled consumer: response held stable, busy stays high
        do_op(1'b0, 16'h4000, 1'b1, 4'd1, 5, r_data, r_id, r_ovf, lat, pulses, bus_ok, stable_ok);
        check("stall stable", {31'd0, stable_ok}, 32'd1);
        check("stall rsp_data", {16'd0, r_data}, 32'h8000);
        check("stall rsp_ovf", {31'd0, r_ovf}, {31'd0, OVF_ON});

        // Both requesters held valid: accept order alternates starting with 0
        do_reset();
        @(negedge clk);
        req0_valid = 1; req0_data = 16'h0A0A; req0_dir = 1; req0_amt = 0;
        req1_valid = 1; req1_data = 16'h0B0B; req1_dir = 1; req1_amt = 0;
        rsp_ready  = 1;
        for (int k = 0; k < 40 && order.size() < 4; k++) begin
            #1;
            if (req0_ready) order.push_back(0);
            if (req1_ready) order.push_back(1);
            if (rsp_valid)
                check("rr rsp_data", {16'd0, rsp_data}, rsp_id ? 32'h0B0B : 32'h0A0A);
            @(negedge clk);
        end
        req0_valid = 0;
        req1_valid = 0;
        @(posedge clk);
        #1 rsp_ready = 0;
        check("rr accept count", order.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr accept %0d", i), (i < order.size()) ? order[i] : -1, i % 2);

        // Reset in the middle of a WAIT step of an amt=5 command
        @(negedge clk);
        req0_valid = 1; req0_data = 16'h0001; req0_dir = 1; req0_amt = 5;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (req0_ready) got = 1;
            else @(negedge clk);
        end
        check("mid-op accept", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1 req0_valid = 0;
        repeat (4) @(negedge clk);
        check("busy before reset", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid-op reset outputs", {rsp_valid, rsp_data, rsp_id, rsp_ovf, su_err, busy,
                                       su_enable, su_func, req0_ready, req1_ready}, 32'd0);
        check("mid-op reset su_a/su_b", {su_a, su_b}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_op(1'b1, 16'h0001, 1'b1, 4'd2, 0, r_data, r_id, r_ovf, lat, pulses, bus_ok, stable_ok);
        check("post-reset rsp_data", {16'd0, r_data}, 32'h0004);
        check("post-reset rsp_id", {31'd0, r_id}, 32'd1);
        check("post-reset latency", lat, 5);

        // Missing su_flag sets a sticky error
        check("su_err clear", {31'd0, su_err}, 32'd0);
        flag_kill = 1;
        do_op(1'b0, 16'h0005, 1'b0, 4'd1, 0, r_data, r_id, r_ovf, lat, pulses, bus_ok, stable_ok);
        flag_kill = 0;
        check("bad-flag rsp_data", {16'd0, r_data}, 32'h0002);
        check("su_err set", {31'd0, su_err}, 32'd1);
        do_op(1'b1, 16'h0003, 1'b1, 4'd1, 0, r_data, r_id, r_ovf, lat, pulses, bus_ok, stable_ok);
        check("su_err sticky", {31'd0, su_err}, 32'd1);
        do_reset();
        #1;
        check("su_err cleared by reset", {31'd0, su_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_shift_ctrl.md
Name: alu_shift_ctrl

Overview:
- Controller that shares the single-bit `shift_unit` between two requesters and sequences multi-bit shifts as repeated 1-bit steps.
- Requester 0 is routed through the unit's `a` port (func 00/01); requester 1 through the `b` port (func 10/11).
- Sits between ALU operand issue logic and `shift_unit`; returns a 16-bit result with an optional left-shift overflow flag over a valid/ready response channel.

Parameters:
- DATA_W, 16: operand/result width; matches `shift_unit` `in_width`.
- AMT_W, 4: shift-amount width; 0..15 steps.
- SU_OUT_W, DATA_W+1: width of `shift_unit` output.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 accepted this cycle
- req0_data  in  DATA_W  signed operand
- req0_dir  in  1  0=arithmetic right, 1=left
- req0_amt  in  AMT_W  number of 1-bit steps
- req1_valid / req1_ready / req1_data / req1_dir / req1_amt: same as req0, for requester 1
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  DATA_W  shifted result
- rsp_id  out  1  requester that owns the result
- rsp_ovf  out  1  left-shift sign overflow (optional feature)
- su_err  out  1  sticky: `su_flag` low when a result was expected
- busy  out  1  state != IDLE
- su_a, su_b  out  DATA_W  to `shift_unit` a/b; the unused port is driven 0
- su_enable  out  1  to `shift_enable`
- su_func  out  2  to `alu_func_shift`
- su_out  in  SU_OUT_W  from `shift_out`
- su_flag  in  1  from `shift_flag`

Behaviour:
- Reset (rst low, any state, including mid-shift): state=IDLE; all outputs 0; rr_last=1, so req0 wins the first tie.
  - `shift_unit` shares the same rst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester != rr_last.
  - reqN_ready is asserted combinationally for the granted requester only, only in IDLE.
  - On the handshake edge: latch cur=data, dir, rem=amt, id=N, ovf=0; update rr_last=N.
  - Next state: amt==0 -> RESP; otherwise ISSUE.
- ISSUE:
  - su_enable=1; su_func={id,dir}.
  - su_a=cur if id==0, else 0; su_b=cur if id==1, else 0.
  - Next state: WAIT.
- WAIT:
  - su_enable=0; su_a=su_b=0.
  - On the edge: cur<=su_out[DATA_W-1:0].
  - The unit's right shift yields the arithmetic result in the low 16 bits (sign-extended before the shift).
  - If su_flag==0: set su_err (sticky until reset).
  - rem<=rem-1; rem==1 -> RESP, else -> ISSUE.
- RESP:
  - rsp_valid=1; rsp_data=cur; rsp_id=id; rsp_ovf=ovf.
  - All held stable until rsp_ready.
  - On handshake -> IDLE; new accept possible the following cycle.
- Latency: accept edge to first rsp_valid cycle = 2*amt+1 cycles (amt=0 -> 1 cycle). Throughput: one command in flight.
- Boundaries:
  - amt=0 issues no su_enable pulse.
  - amt=15 gives 30 unit cycles; right shifts saturate to 0x0000 or 0xFFFF.
  - Requests arriving while busy wait; their valid/data must be held by the requester.
  - Arbitration evaluates only in IDLE.

Optional Feature:
- Macro: ALU_SHIFT_CTRL_OVF_EN.
- Defined: in WAIT with dir=1, if su_out[DATA_W-1] != cur[DATA_W-1], set ovf. ovf is sticky per transaction and cleared on accept. Right shifts never set ovf.
- Undefined: rsp_ovf tied 0; no ovf register.

Decomposition:
- Package alu_pkg: state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3), SHIFT_DIR_RIGHT=0 / SHIFT_DIR_LEFT=1, func constants 00/01/10/11, DATA_W default.
- Optional sub-module: rr_arb2, a 2-input round-robin arbiter (valid in, one-hot grant out, last-pointer update on accept).
- `shift_unit` is instantiated by the parent, not inside this block.

Test Plan:
1. req0 0x0003 left amt 3 -> rsp_data 0x0018, rsp_id 0, rsp_ovf 0, rsp_valid 7 cycles after accept; three su_enable pulses with su_func=01.
2. req1 0x8000 right amt 4 -> rsp_data 0xF800, rsp_id 1; su_func=10 on each issue; su_a stays 0.
3. req0 and req1 held valid continuously, rsp_ready=1 -> accept order 0,1,0,1.
4. req0 0x1234 amt 0 -> rsp_data 0x1234 one cycle after accept; no su_enable pulse.
5. Left-shift overflow:
   - req0 0x4000 left amt 1 -> 0x8000 with rsp_ovf 1 (macro defined), 0 (undefined).
   - Hold rsp_ready=0 for 5 cycles -> rsp outputs stable; busy=1.
6. Reset and error handling:
   - rst low during WAIT of an amt=5 op -> outputs 0, busy 0.
   - Following req1 0x0001 left amt 2 -> 0x0004.
   - Force su_flag=0 during a WAIT -> su_err stays 1 until reset.
